// File: rtl/click_classifier.sv
// click_classifier: groups debounced key-press strobes into bursts and reports burst size.
// Optional CLICK_CLASSIFIER_TOTAL_EN adds a free-running 16-bit press counter output.
module click_classifier #(
    parameter int CLK_FREQ_MHZ = 20,
    parameter int WINDOW_US    = 250,
    parameter int MAX_CLICKS   = 3
) (
    input  logic                              clk_i,
    input  logic                              srst_i,
    input  logic                              key_pressed_stb_i,
    output logic [$clog2(MAX_CLICKS+1)-1:0]   clicks_o,
    output logic                              clicks_valid_o,
`ifdef CLICK_CLASSIFIER_TOTAL_EN
    output logic [15:0]                       total_clicks_o,
`endif
    output logic                              busy_o
);

    localparam int WINDOW_CYCLES = CLK_FREQ_MHZ * WINDOW_US;
    localparam int CW            = $clog2(MAX_CLICKS + 1);
    localparam int TW            = $clog2(WINDOW_CYCLES);

    localparam logic [CW-1:0] C_MAX      = CW'(MAX_CLICKS);
    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [TW-1:0] T_LAST     = TW'(WINDOW_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE      = TW'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OPEN = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_timer;
    logic [CW-1:0]   r_clicks;
    logic            r_valid;
    logic            r_busy;

    logic [CW-1:0]   w_cnt_inc;
    logic            w_hit_max;
    logic            w_timeout;

    assign w_cnt_inc = r_cnt + C_ONE;
    assign w_hit_max = (w_cnt_inc == C_MAX);
    assign w_timeout = (r_timer == T_LAST);

    // A strobe always beats a timeout landing on the same edge.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_timer  <= '0;
            r_clicks <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (key_pressed_stb_i) begin
                        r_cnt   <= C_ONE;
                        r_timer <= '0;
                        r_state <= S_OPEN;
                        r_busy  <= 1'b1;
                    end
                end
                S_OPEN: begin
                    if (key_pressed_stb_i && w_hit_max) begin
                        r_clicks <= C_MAX;
                        r_valid  <= 1'b1;
                        r_cnt    <= '0;
                        r_timer  <= '0;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end else if (key_pressed_stb_i) begin
                        r_cnt   <= w_cnt_inc;
                        r_timer <= '0;
                    end else if (w_timeout) begin
                        r_clicks <= r_cnt;
                        r_valid  <= 1'b1;
                        r_cnt    <= '0;
                        r_timer  <= '0;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end else begin
                        r_timer <= r_timer + T_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_timer <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLICK_CLASSIFIER_TOTAL_EN
    logic [15:0] r_total;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_total <= '0;
        end else if (key_pressed_stb_i) begin
            r_total <= r_total + 16'd1;
        end
    end

    assign total_clicks_o = r_total;
`endif

    assign clicks_o       = r_clicks;
    assign clicks_valid_o = r_valid;
    assign busy_o         = r_busy;

endmodule

// File: tb/tb_click_classifier.sv
// Self-checking bench for click_classifier: directed scenarios plus random strobes
// compared each cycle against a timestamp-based burst model.
module tb_click_classifier;

    localparam int W   = 10;
    localparam int MAX = 3;

    logic       clk_i = 1'b0;
    logic       srst_i = 1'b0;
    logic       key_pressed_stb_i = 1'b0;
    logic [1:0] clicks_o;
    logic       clicks_valid_o;
    logic       busy_o;
`ifdef CLICK_CLASSIFIER_TOTAL_EN
    logic [15:0] total_clicks_o;
`endif

    click_classifier #(
        .CLK_FREQ_MHZ(1),
        .WINDOW_US(10),
        .MAX_CLICKS(MAX)
    ) dut (
        .clk_i(clk_i),
        .srst_i(srst_i),
        .key_pressed_stb_i(key_pressed_stb_i),
        .clicks_o(clicks_o),
        .clicks_valid_o(clicks_valid_o),
`ifdef CLICK_CLASSIFIER_TOTAL_EN
        .total_clicks_o(total_clicks_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: burst = list of press timestamps, closed by gap or size.
    int  m_now;
    bit  m_open;
    int  m_count;
    int  m_last;
    int  m_clicks;
    bit  m_valid;
    bit  m_busy;
    int  m_total;

    bit  stb_at [0:127];
    bit  vlog   [0:127];
    int  clog   [0:127];
    bit  blog   [0:127];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_edge(input bit s, input bit r);
        m_now++;
        if (r) begin
            m_open = 0; m_count = 0; m_clicks = 0;
            m_valid = 0; m_busy = 0; m_total = 0;
            return;
        end
        m_valid = 0;
        if (s) m_total = (m_total + 1) % 65536;
        if (!m_open) begin
            if (s) begin
                m_open = 1; m_count = 1; m_last = m_now;
            end
        end else if (s) begin
            m_count++;
            m_last = m_now;
            if (m_count == MAX) begin
                m_clicks = m_count; m_valid = 1; m_open = 0;
            end
        end else if (m_now - m_last == W) begin
            m_clicks = m_count; m_valid = 1; m_open = 0;
        end
        m_busy = m_open;
    endfunction

    task automatic step(input bit s, input bit r, input int e);
        key_pressed_stb_i = s;
        srst_i = r;
        @(posedge clk_i);
        model_edge(s, r);
        #1;
        chk("clicks", 32'(clicks_o), 32'(m_clicks));
        chk("valid", 32'(clicks_valid_o), 32'(m_valid));
        chk("busy", 32'(busy_o), 32'(m_busy));
`ifdef CLICK_CLASSIFIER_TOTAL_EN
        chk("total", 32'(total_clicks_o), 32'(m_total));
`endif
        if (e >= 0 && e < 128) begin
            vlog[e] = clicks_valid_o;
            clog[e] = int'(clicks_o);
            blog[e] = busy_o;
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, -1);
        step(1'b0, 1'b1, -1);
        chk("rst_clicks", 32'(clicks_o), 0);
        chk("rst_valid", 32'(clicks_valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        for (int i = 0; i < 128; i++) begin
            stb_at[i] = 0; vlog[i] = 0; clog[i] = 0; blog[i] = 0;
        end
    endtask

    task automatic run(input int n, input int rst_e);
        for (int e = 1; e <= n; e++) step(stb_at[e], e == rst_e, e);
    endtask

    function automatic int nvalid(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) c += int'(vlog[i]);
        return c;
    endfunction

    initial begin
        m_now = 0; m_open = 0; m_count = 0; m_last = 0;
        m_clicks = 0; m_valid = 0; m_busy = 0; m_total = 0;
        @(negedge clk_i);

        // single press
        do_reset();
        stb_at[5] = 1;
        run(40, -1);
        chk("s1_valid15", 32'(vlog[15]), 1);
        chk("s1_clicks15", 32'(clog[15]), 1);
        chk("s1_nvalid", 32'(nvalid(1, 40)), 1);
        chk("s1_busy4", 32'(blog[4]), 0);
        chk("s1_busy5", 32'(blog[5]), 1);
        chk("s1_busy14", 32'(blog[14]), 1);
        chk("s1_busy15", 32'(blog[15]), 0);

        // double press
        do_reset();
        stb_at[5] = 1; stb_at[14] = 1;
        run(40, -1);
        chk("s2_valid15", 32'(vlog[15]), 0);
        chk("s2_valid24", 32'(vlog[24]), 1);
        chk("s2_clicks24", 32'(clog[24]), 2);
        chk("s2_nvalid", 32'(nvalid(1, 40)), 1);

        // max burst
        do_reset();
        stb_at[5] = 1; stb_at[8] = 1; stb_at[11] = 1;
        run(40, -1);
        chk("s3_valid11", 32'(vlog[11]), 1);
        chk("s3_clicks11", 32'(clog[11]), 3);
        chk("s3_busy11", 32'(blog[11]), 0);
        chk("s3_nvalid", 32'(nvalid(1, 40)), 1);

        // strobe on the timeout edge
        do_reset();
        stb_at[5] = 1; stb_at[15] = 1;
        run(40, -1);
        chk("s4_valid15", 32'(vlog[15]), 0);
        chk("s4_valid25", 32'(vlog[25]), 1);
        chk("s4_clicks25", 32'(clog[25]), 2);

        // strobe during the report cycle
        do_reset();
        stb_at[5] = 1; stb_at[16] = 1;
        run(40, -1);
        chk("s5_valid15", 32'(vlog[15]), 1);
        chk("s5_busy16", 32'(blog[16]), 1);
        chk("s5_valid26", 32'(vlog[26]), 1);
        chk("s5_clicks26", 32'(clog[26]), 1);
        chk("s5_nvalid", 32'(nvalid(1, 40)), 2);

        // reset mid-burst
        do_reset();
        stb_at[5] = 1; stb_at[7] = 1; stb_at[20] = 1;
        run(40, 9);
        chk("s6_busy9", 32'(blog[9]), 0);
        chk("s6_clicks9", 32'(clog[9]), 0);
        chk("s6_nvalid", 32'(nvalid(1, 29)), 0);
        chk("s6_valid30", 32'(vlog[30]), 1);
        chk("s6_clicks30", 32'(clog[30]), 1);

`ifdef CLICK_CLASSIFIER_TOTAL_EN
        do_reset();
        stb_at[2] = 1; stb_at[4] = 1;
        stb_at[20] = 1; stb_at[22] = 1; stb_at[24] = 1;
        stb_at[40] = 1; stb_at[43] = 1;
        run(60, -1);
        chk("tot_seven", 32'(total_clicks_o), 7);
        do_reset();
        for (int i = 0; i < 65535; i++) step(1'b1, 1'b0, -1);
        chk("tot_ffff", 32'(total_clicks_o), 32'h0000_FFFF);
        step(1'b1, 1'b0, -1);
        chk("tot_wrap", 32'(total_clicks_o), 0);
`endif

        // random strobes and occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 399) == 0, -1);
        end
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 1) == 0, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
